coffee_controller: RTL and testbench



---
 rtl/coffee_controller.sv | 182 ++++++++++++++++++
 tb/tb_coffee_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/coffee_controller.sv
// Coffee machine front panel: button conditioning, drink selection,
// timed recipe FSM and display/LED decode. Optional macro: COFFEE_ABORT_EN.

// Synchronizes, debounces and edge-detects one active-low button.
module coffee_debounce #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Accept a new level after enough identical samples; flag falling edges.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_q & ~level_d;
    end

    // Synchronizer and debounce state; idle level is released (1).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;
endmodule

module coffee_controller #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int STEP_CYCLES     = 400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       next_button,
    input  logic       select_button,
    output logic [6:0] seg_type,
    output logic [6:0] seg_state,
    output logic [4:0] led
);
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_A    = 4'd3,
        ST_C    = 4'd4,
        ST_L    = 4'd5,
        ST_U    = 4'd6,
        ST_E    = 4'd7,
        ST_F    = 4'd8
    } state_t;

    localparam logic [1:0] SEL_ESP = 2'b00;
    localparam logic [1:0] SEL_LAT = 2'b01;
    localparam logic [1:0] SEL_CAP = 2'b10;
    localparam int         TW      = $clog2(STEP_CYCLES);

    logic          next_pulse, select_pulse;
    state_t        display_state, display_state_d;
    logic [1:0]    coffee_sel, coffee_sel_d;
    logic [1:0]    recipe_q, recipe_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          step_done;

    coffee_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .clk   (clk),
        .reset (reset),
        .btn_n (next_button),
        .press (next_pulse)
    );

    coffee_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_select_db (
        .clk   (clk),
        .reset (reset),
        .btn_n (select_button),
        .press (select_pulse)
    );

    assign step_done = (timer_q == TW'(STEP_CYCLES - 1));

    // Next-state: selection in IDLE, recipe stepping and stage timer.
    always_comb begin
        display_state_d = display_state;
        coffee_sel_d    = coffee_sel;
        recipe_d        = recipe_q;
        timer_d         = timer_q + 1'b1;
        unique case (display_state)
            ST_IDLE: begin
                timer_d = '0;
                if (select_pulse) begin
                    recipe_d        = coffee_sel;
                    display_state_d = ST_A;
                end else if (next_pulse) begin
                    unique case (coffee_sel)
                        SEL_ESP: coffee_sel_d = SEL_LAT;
                        SEL_LAT: coffee_sel_d = SEL_CAP;
                        default: coffee_sel_d = SEL_ESP;
                    endcase
                end
            end
            ST_A: if (step_done) display_state_d = ST_C;
            ST_C: if (step_done)
                display_state_d = (recipe_q == SEL_ESP) ? ST_U : ST_L;
            ST_L: if (step_done)
                display_state_d = (recipe_q == SEL_CAP) ? ST_E : ST_U;
            ST_E: if (step_done) display_state_d = ST_U;
            ST_U: if (step_done) display_state_d = ST_F;
            ST_F: if (step_done) display_state_d = ST_IDLE;
            default: display_state_d = ST_IDLE;
        endcase
`ifdef COFFEE_ABORT_EN
        if (display_state != ST_IDLE && next_pulse) begin
            display_state_d = ST_IDLE;
        end
`endif
        if (display_state_d != display_state) begin
            timer_d = '0;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            display_state <= ST_IDLE;
            coffee_sel    <= SEL_ESP;
            recipe_q      <= SEL_ESP;
            timer_q       <= '0;
        end else begin
            display_state <= display_state_d;
            coffee_sel    <= coffee_sel_d;
            recipe_q      <= recipe_d;
            timer_q       <= timer_d;
        end
    end

    // Drink letter decoded from the registered selection.
    always_comb begin
        unique case (coffee_sel)
            SEL_LAT: seg_type = 7'b1000111;
            SEL_CAP: seg_type = 7'b1000110;
            default: seg_type = 7'b0000110;
        endcase
    end

    // Stage letter and ingredient LEDs decoded from the registered stage.
    always_comb begin
        seg_state = 7'b0111111;
        led       = 5'b00000;
        unique case (display_state)
            ST_A: begin seg_state = 7'b0001000; led = 5'b00001; end
            ST_C: begin seg_state = 7'b1000110; led = 5'b00010; end
            ST_L: begin seg_state = 7'b1000111; led = 5'b00100; end
            ST_U: begin seg_state = 7'b1000001; led = 5'b01000; end
            ST_E: begin seg_state = 7'b0000110; led = 5'b10000; end
            ST_F: begin seg_state = 7'b0001110; led = 5'b11111; end
            default: begin seg_state = 7'b0111111; led = 5'b00000; end
        endcase
    end
endmodule

// File: tb/tb_coffee_controller.sv
// Directed testbench for coffee_controller.
// Covers reset, selection, recipes, glitches, ignored presses, mid-run reset.
module tb_coffee_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       next_button = 1'b1;
    logic       select_button = 1'b1;
    logic [6:0] seg_type, seg_state;
    logic [4:0] led;

    int n_tests = 0;
    int n_fail = 0;

    coffee_controller dut (
        .clk           (clk),
        .reset         (reset),
        .next_button   (next_button),
        .select_button (select_button),
        .seg_type      (seg_type),
        .seg_state     (seg_state),
        .led           (led)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Next press with 30 low and 50 high cycles; counts selection changes.
    task automatic next_press_count(input logic [1:0] exp_sel,
                                    input logic [6:0] exp_seg);
        int changes = 0;
        logic [1:0] prev;
        prev = dut.coffee_sel;
        for (int i = 0; i < 80; i++) begin
            next_button = (i < 30) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (dut.coffee_sel !== prev) changes++;
            prev = dut.coffee_sel;
        end
        check("next_changes", changes, 1);
        check("next_sel", dut.coffee_sel, exp_sel);
        check("next_seg_type", seg_type, exp_seg);
    endtask

    task automatic press_select(input int low);
        select_button = 1'b0;
        wait_cycles(low);
        select_button = 1'b1;
    endtask

    task automatic press_next(input int low);
        next_button = 1'b0;
        wait_cycles(low);
        next_button = 1'b1;
    endtask

    task automatic wait_state(input logic [3:0] st, input int limit);
        int n = 0;
        while (dut.display_state !== st && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Follows one full recipe; st/ld hold up to six stages, low first.
    task automatic watch_recipe(input int n, input logic [23:0] st,
                                input logic [29:0] ld);
        int len;
        wait_state(st[3:0], 40);
        for (int i = 0; i < n; i++) begin
            check("stage", dut.display_state, st[i*4 +: 4]);
            check("stage_led", led, ld[i*5 +: 5]);
            len = 0;
            while (dut.display_state === st[i*4 +: 4] && len < 500) begin
                len++;
                @(negedge clk);
            end
            check("stage_len", len, 400);
        end
        check("end_state", dut.display_state, 0);
        check("end_led", led, 0);
        check("end_seg_state", seg_state, 7'b0111111);
    endtask

    // Disturbances during stage C of an espresso run.
    task automatic disturb_c();
        wait_state(4'd4, 900);
        wait_cycles(20);
        press_next(5);
        wait_cycles(20);
        press_select(30);
    endtask

    initial begin
        wait_cycles(10);
        check("rst_sel", dut.coffee_sel, 0);
        check("rst_state", dut.display_state, 0);
        check("rst_led", led, 0);
        check("rst_seg_type", seg_type, 7'b0000110);
        check("rst_seg_state", seg_state, 7'b0111111);
        reset = 1'b0;
        wait_cycles(20);
        check("post_rst_state", dut.display_state, 0);

        next_press_count(2'b01, 7'b1000111);
        next_press_count(2'b10, 7'b1000110);
        next_press_count(2'b00, 7'b0000110);

        press_next(5);
        wait_cycles(30);
        check("glitch_idle_sel", dut.coffee_sel, 0);

        fork
            press_select(30);
            watch_recipe(4, {8'h0, 4'd8, 4'd6, 4'd4, 4'd3},
                         {10'h0, 5'b11111, 5'b01000, 5'b00010, 5'b00001});
        join
        check("esp_sel", dut.coffee_sel, 0);

        next_press_count(2'b01, 7'b1000111);
        next_press_count(2'b10, 7'b1000110);
        fork
            press_select(30);
            watch_recipe(6, {4'd8, 4'd6, 4'd7, 4'd5, 4'd4, 4'd3},
                         {5'b11111, 5'b01000, 5'b10000,
                          5'b00100, 5'b00010, 5'b00001});
`ifndef COFFEE_ABORT_EN
            begin
                wait_cycles(200);
                press_next(30);
                wait_cycles(600);
                press_next(30);
            end
`endif
        join
        check("cap_sel", dut.coffee_sel, 2);
        check("cap_seg_type", seg_type, 7'b1000110);

        next_press_count(2'b00, 7'b0000110);
`ifndef COFFEE_ABORT_EN
        fork
            press_select(30);
            watch_recipe(4, {8'h0, 4'd8, 4'd6, 4'd4, 4'd3},
                         {10'h0, 5'b11111, 5'b01000, 5'b00010, 5'b00001});
            disturb_c();
        join
        wait_cycles(30);
        check("no_restart", dut.display_state, 0);
        check("dist_sel", dut.coffee_sel, 0);
`endif

        next_press_count(2'b01, 7'b1000111);
        press_select(30);
        wait_state(4'd5, 1000);
        check("latte_in_l", dut.display_state, 5);
        check("latte_led", led, 5'b00100);
`ifdef COFFEE_ABORT_EN
        press_next(30);
        check("abort_state", dut.display_state, 0);
        check("abort_led", led, 0);
        check("abort_seg", seg_state, 7'b0111111);
        check("abort_sel", dut.coffee_sel, 1);
        press_select(30);
        wait_state(4'd5, 1000);
        check("relatte_in_l", dut.display_state, 5);
`endif
        wait_cycles(50);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_state", dut.display_state, 0);
        check("mid_rst_led", led, 0);
        check("mid_rst_seg_state", seg_state, 7'b0111111);
        check("mid_rst_seg_type", seg_type, 7'b0000110);
        check("mid_rst_sel", dut.coffee_sel, 0);
        wait_cycles(5);
        reset = 1'b0;
        wait_cycles(30);
        check("rel_no_start", dut.display_state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
